mux_scan_sequencer: RTL and testbench
=====================================

Name: mux_scan_sequencer

Overview:
- Sequential driver/collector that sits directly around the 4:1 structural multiplexer.
- Upstream role: drives the mux select lines address0/address1 through 0,1,2,3.
- Downstream role: consumes the mux output, waiting a programmable settle time after each select change so that gate propagation (50-unit gates, three levels) has resolved.
- Assembles the four sampled bits into a 4-bit result word and signals completion with a one-cycle done pulse; supports single-shot and continuous scanning.

Parameters:
- SETTLE_CYCLES, 2, clock cycles to wait after each select change before sampling mux_out; legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- resetn  input  1  synchronous, active-low reset, sampled on the rising edge of clk
- start  input  1  begin a scan when idle; level-sampled
- continuous  input  1  when 1 at end of scan, restart immediately instead of returning to idle
- address0  output  1  mux select bit 0 (registered)
- address1  output  1  mux select bit 1 (registered)
- mux_out  input  1  output of the multiplexer being scanned
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when result updates
- result  output  4  result[i] = mux_out sampled with address == i; held between scans

Behaviour:
- Reset (resetn=0 at a clk edge): state IDLE; address1:address0=00; busy=0; done=0; result=0000; shadow register=0000; settle counter=0.
- Reset overrides everything, including mid-scan; a partial scan is discarded and result is not updated.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 -> SETTLE; address=00; counter=0.
  - start=0 -> stay; address stays 00.
- SETTLE:
  - Counter increments each cycle.
  - When counter==SETTLE_CYCLES-1 -> SAMPLE.
  - Address is held constant throughout.
- SAMPLE (one cycle):
  - shadow[address] <= mux_out.
  - address<3 -> address+1, counter=0, SETTLE.
  - address==3 -> DONE.
- DONE (one cycle):
  - result <= shadow, with the final bit already included; done=1 this cycle only.
  - continuous=1 -> SETTLE with address=00, counter=0.
  - Otherwise -> IDLE, address=00.
- Timing:
  - Address changes only on the edge entering SETTLE, so each select value is stable for exactly SETTLE_CYCLES+1 cycles before capture.
  - Scan latency from start accepted to done high = 4*(SETTLE_CYCLES+1)+1 cycles; 13 cycles at the default.
- Edge cases:
  - start while busy: ignored; no restart, no queuing.
  - continuous is sampled only in DONE; changing it mid-scan has no effect until the scan ends.
  - result is stable and valid from the cycle done is high until the next done.
  - mux_out X/Z at a sample point: the X is captured as-is into shadow/result. There is no masking or silent substitution; this makes an X on a selected input visible to the bench.
  - Address wrap: after address 11 the block never emits 00 inside the same scan; 00 only reappears via DONE->SETTLE or IDLE.
- busy=1 from the cycle after start is accepted through the DONE cycle inclusive; 0 in IDLE.
- Unused counter values ≥ SETTLE_CYCLES are unreachable; if reached due to corruption, treat as the terminal count.

Test Plan:
1. Reset then single scan: inputs in3..in0=1010, start pulse, continuous=0 -> address sequence 00,01,10,11 each held 3 cycles; done pulses once 13 cycles after start accepted; result=1010; busy=0 next cycle.
2. Reset mid-scan: assert resetn=0 for one edge while address=10 -> next cycle address=00, busy=0, done=0, result=0000 (prior result discarded); a following scan of 0110 yields result=0110.
3. Continuous mode: continuous=1, inputs 1100 then change to 0011 during the second scan's SETTLE at address 00 -> done pulses every 13 cycles; first result=1100, second=0011, with no idle cycle between scans.
4. start held high while busy plus re-pulses: exactly one done per 13 cycles with continuous=0; a start still high in IDLE after DONE launches a new scan the next cycle.
5. Select isolation: unselected inputs driven to X, selected inputs 0/1 (pattern 0101) -> result=0101 with no X bits; then in2=X while selected -> result[2]=X.
6. SETTLE_CYCLES=1 and =5 builds: latency is 9 and 25 cycles respectively; address hold time is 2 and 6 cycles.

Source files
------------

// File: rtl/mux_scan_if.sv
// Bundle between the scan sequencer and the 4:1 mux it drives and samples.
// Handshake: start is level-sampled only while the sequencer is idle; busy
// stays high from the cycle after start is taken through the done cycle;
// done is a one-cycle pulse, and result is valid from that cycle until the
// next done pulse.
interface mux_scan_if;
    logic       start;
    logic       continuous;
    logic       address0;
    logic       address1;
    logic       mux_out;
    logic       busy;
    logic       done;
    logic [3:0] result;

    // Controller / mux side: requests scans and returns the mux output.
    modport master (
        output start, continuous, mux_out,
        input  address0, address1, busy, done, result
    );

    // Sequencer side.
    modport slave (
        input  start, continuous, mux_out,
        output address0, address1, busy, done, result
    );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Walks the mux select through 0..3. After each select change it waits
// SETTLE_CYCLES so the gate network can resolve, then captures mux_out.
// The four captured bits form result, and done pulses for one cycle.
module mux_scan_sequencer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    mux_scan_if.slave   bus,
    output logic [1:0]  dbg_state
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_nx;
    logic [1:0] addr;
    logic [3:0] cnt;
    logic [3:0] shadow;
    logic [3:0] shadow_nx;
    logic [3:0] result_q;
    logic       settle_end;

    // Counts at or past the terminal value end the settle phase. This also
    // recovers from a corrupted counter.
    assign settle_end = (cnt >= CNT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // Next-state logic. start is ignored outside IDLE, and continuous is
    // looked at only in DONE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = SETTLE;
            SETTLE:  if (settle_end) state_nx = SAMPLE;
            SAMPLE:  state_nx = (addr == 2'd3) ? DONE : SETTLE;
            DONE:    state_nx = bus.continuous ? SETTLE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Shadow with the current sample merged in. This lets the last bit go
    // straight into result, so result is valid in the done cycle.
    always_comb begin
        shadow_nx       = shadow;
        shadow_nx[addr] = bus.mux_out;
    end

    // Datapath: the select only advances on the edge leaving SAMPLE, so it is
    // held for SETTLE_CYCLES+1 cycles. An X on mux_out is captured unchanged.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr     <= 2'd0;
            cnt      <= 4'd0;
            shadow   <= 4'd0;
            result_q <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    addr <= 2'd0;
                    cnt  <= 4'd0;
                end
                SETTLE: begin
                    if (!settle_end) cnt <= cnt + 4'd1;
                end
                SAMPLE: begin
                    shadow <= shadow_nx;
                    cnt    <= 4'd0;
                    if (addr != 2'd3) addr     <= addr + 2'd1;
                    else              result_q <= shadow_nx;
                end
                DONE: begin
                    addr <= 2'd0;
                    cnt  <= 4'd0;
                end
                default: begin
                    addr <= 2'd0;
                    cnt  <= 4'd0;
                end
            endcase
        end
    end

    // Output decode from the registered state.
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            IDLE:    bus.busy = 1'b0;
            DONE:    begin bus.busy = 1'b1; bus.done = 1'b1; end
            default: bus.busy = 1'b1;
        endcase
    end

    assign bus.address0 = addr[0];
    assign bus.address1 = addr[1];
    assign bus.result   = result_q;
    assign dbg_state    = state;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer. Three instances run side by side with
// SETTLE_CYCLES = 2, 1 and 5. A behavioural 4:1 mux feeds each instance.
module tb_mux_scan_sequencer;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mux_scan_if bus0 ();
    mux_scan_if bus1 ();
    mux_scan_if bus2 ();

    logic [1:0] dbg0, dbg1, dbg2;

    mux_scan_sequencer #(.SETTLE_CYCLES(2)) dut0 (.clk(clk), .resetn(resetn), .bus(bus0.slave), .dbg_state(dbg0));
    mux_scan_sequencer #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .resetn(resetn), .bus(bus1.slave), .dbg_state(dbg1));
    mux_scan_sequencer #(.SETTLE_CYCLES(5)) dut2 (.clk(clk), .resetn(resetn), .bus(bus2.slave), .dbg_state(dbg2));

    // Shared stimulus.
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic [3:0] in_vec = 4'd0;
    logic       iso = 1'b0;
    logic [3:0] in_bus;

    logic [1:0] addr_v [3];
    logic [3:0] result_v [3];
    logic [2:0] done_v;
    logic [2:0] busy_v;

    assign addr_v[0]   = {bus0.address1, bus0.address0};
    assign addr_v[1]   = {bus1.address1, bus1.address0};
    assign addr_v[2]   = {bus2.address1, bus2.address0};
    assign result_v[0] = bus0.result;
    assign result_v[1] = bus1.result;
    assign result_v[2] = bus2.result;
    assign done_v      = {bus2.done, bus1.done, bus0.done};
    assign busy_v      = {bus2.busy, bus1.busy, bus0.busy};

    assign bus0.start = start;
    assign bus1.start = start;
    assign bus2.start = start;
    assign bus0.continuous = cont;
    assign bus1.continuous = 1'b0;
    assign bus2.continuous = 1'b0;

    // In isolation mode the main instance sees X on every unselected input.
    always_comb begin
        in_bus = in_vec;
        if (iso) begin
            in_bus = 4'bxxxx;
            in_bus[addr_v[0]] = in_vec[addr_v[0]];
        end
    end
    assign bus0.mux_out = in_bus[addr_v[0]];
    assign bus1.mux_out = in_vec[addr_v[1]];
    assign bus2.mux_out = in_vec[addr_v[2]];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic int s_of(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            default: return 5;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] pat;
        logic       iso_m;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs [6];

    // One single-shot scan on all three instances. Samples taken #1 after
    // each edge, with c=0 being the first cycle after the accepting edge. For
    // settle time S, done is expected at c = 4*(S+1). That is the
    // 4*(S+1)+1-th cycle counting the accept cycle: 13 at S=2. The select
    // for cycle c is expected to be c/(S+1).
    task automatic run_scan(input logic [3:0] pat, input logic iso_m, input logic [3:0] exp);
        int   lat [3];
        int   ndone [3];
        logic bad_seq [3];
        logic busy_after [3];
        in_vec = pat;
        iso    = iso_m;
        start  = 1'b1;
        step();
        start  = 1'b0;
        for (int d = 0; d < 3; d++) begin
            lat[d] = -1; ndone[d] = 0; bad_seq[d] = 1'b0; busy_after[d] = 1'b1;
        end
        for (int c = 0; c < 40; c++) begin
            for (int d = 0; d < 3; d++) begin
                if (done_v[d]) begin
                    ndone[d]++;
                    if (lat[d] < 0) lat[d] = c;
                end else if (lat[d] < 0) begin
                    if (addr_v[d] !== 2'(c / (s_of(d) + 1))) bad_seq[d] = 1'b1;
                end else if (c == lat[d] + 1) begin
                    busy_after[d] = busy_v[d];
                end
            end
            step();
        end
        for (int d = 0; d < 3; d++) begin
            check($sformatf("latency[S=%0d]", s_of(d)), lat[d], 4 * (s_of(d) + 1));
            check($sformatf("done_count[S=%0d]", s_of(d)), ndone[d], 1);
            check($sformatf("addr_hold[S=%0d]", s_of(d)), {31'd0, bad_seq[d]}, 0);
            check($sformatf("busy_after[S=%0d]", s_of(d)), {31'd0, busy_after[d]}, 0);
            check($sformatf("result[S=%0d] pat=%b", s_of(d), pat), {28'd0, result_v[d]}, {28'd0, exp});
        end
        iso = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int w;
        int first_done;
        int second_done;
        int ndone;
        logic busy_idle;
        logic busy_re;

        vecs[0] = '{4'b1010, 1'b0, 4'b1010};
        vecs[1] = '{4'b1111, 1'b0, 4'b1111};
        vecs[2] = '{4'b0000, 1'b0, 4'b0000};
        vecs[3] = '{4'b1001, 1'b0, 4'b1001};
        vecs[4] = '{4'b0101, 1'b1, 4'b0101};
        vecs[5] = '{4'b0x01, 1'b0, 4'b0x01};

        // Reset state.
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
        check("rst_addr",   {30'd0, addr_v[0]}, 0);
        check("rst_busy",   {31'd0, bus0.busy}, 0);
        check("rst_done",   {31'd0, bus0.done}, 0);
        check("rst_result", {28'd0, bus0.result}, 0);
        check("rst_state",  {30'd0, dbg0}, 0);
        step();

        // Table of single scans on all three settle settings.
        for (int i = 0; i < 6; i++) run_scan(vecs[i].pat, vecs[i].iso_m, vecs[i].exp);

        // Reset while address is 2 discards the partial scan and the old result.
        in_vec = 4'b1111;
        start  = 1'b1;
        step();
        start  = 1'b0;
        w = 0;
        while (addr_v[0] !== 2'd2 && w < 30) begin step(); w++; end
        check("reach_addr2", {31'd0, w < 30}, 1);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        check("midrst_addr",   {30'd0, addr_v[0]}, 0);
        check("midrst_busy",   {31'd0, bus0.busy}, 0);
        check("midrst_done",   {31'd0, bus0.done}, 0);
        check("midrst_result", {28'd0, bus0.result}, 0);
        step();
        run_scan(4'b0110, 1'b0, 4'b0110);

        // Continuous mode: back-to-back scans, inputs change during scan two.
        cont   = 1'b1;
        in_vec = 4'b1100;
        start  = 1'b1;
        step();
        start  = 1'b0;
        c = 0;
        while (!bus0.done && c < 40) begin step(); c++; end
        check("cont_lat1",    c, 12);
        check("cont_result1", {28'd0, bus0.result}, {28'd0, 4'b1100});
        step();
        check("cont_no_idle", {31'd0, bus0.busy}, 1);
        check("cont_addr0",   {30'd0, addr_v[0]}, 0);
        in_vec = 4'b0011;
        cont   = 1'b0;
        c = 1;
        while (!bus0.done && c < 40) begin step(); c++; end
        check("cont_period",  c, 13);
        check("cont_result2", {28'd0, bus0.result}, {28'd0, 4'b0011});
        step();
        check("cont_stop_busy", {31'd0, bus0.busy}, 0);
        for (int i = 0; i < 30; i++) step();

        // start held high with a re-pulse while busy. Only one done per scan,
        // then the held start relaunches from IDLE on the next edge.
        in_vec = 4'b1001;
        start  = 1'b1;
        step();
        first_done = -1; second_done = -1; ndone = 0;
        busy_idle = 1'b1; busy_re = 1'b0;
        for (int k = 0; k < 28; k++) begin
            if (k == 3) start = 1'b0;
            if (k == 4) start = 1'b1;
            if (bus0.done) begin
                ndone++;
                if (first_done < 0) first_done = k;
                else if (second_done < 0) second_done = k;
            end
            if (k == 13) busy_idle = bus0.busy;
            if (k == 14) busy_re = bus0.busy;
            step();
        end
        start = 1'b0;
        check("hold_first_done",  first_done, 12);
        check("hold_idle_busy",   {31'd0, busy_idle}, 0);
        check("hold_relaunch",    {31'd0, busy_re}, 1);
        check("hold_second_done", second_done, 26);
        check("hold_done_count",  ndone, 2);
        for (int i = 0; i < 40; i++) step();
        check("hold_end_state",  {30'd0, dbg0}, 0);
        check("hold_end_result", {28'd0, bus0.result}, {28'd0, 4'b1001});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
